// File: rtl/mem_arbiter.sv
// mem_arbiter
// ------------------------------------------------------------------------------
// Two-requester arbiter and sequencer for the 512 x 32 unified memory.
// Port 0 is instruction fetch and port 1 is the datapath load/store unit.
// Their accesses are serialised onto the single memory port as IDLE -> ACCESS -> RESP.
// Read data is latched at the end of ACCESS.
// A one-cycle ack is returned to the owner during RESP.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins an IDLE tie
//                          undefined : round-robin between the two ports
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req0/addr0/wr0/wdata0      port 0 request; fields held stable until ack0
//   ack0, rdata0               port 0 completion pulse and read data
//   req1/addr1/wr1/wdata1      port 1 request
//   ack1, rdata1               port 1 completion pulse and read data
//   mem_addr/mem_din/mem_write memory Address/Datain/Write pins
//   mem_dout                   memory Dataout (combinational read)
//   busy                       high while in ACCESS or RESP
// ------------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              wr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] din_q;
  logic              owner;

  logic [1:0] req_vec;
  logic [1:0] cand;
  logic       grant_valid;
  logic       grant_idx;
  logic [1:0] ack_vec;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  assign req_vec = {req1, req0};

  // Candidates for a new grant.
  // In RESP only the non-owner is considered, because the owner's req is
  // still the one being acknowledged.
  always_comb begin
    cand = 2'b00;
    case (state_reg)
      IDLE:    cand = req_vec;
      RESP:    cand = owner ? {1'b0, req0} : {req1, 1'b0};
      default: cand = 2'b00;
    endcase
  end

  always_comb begin
    grant_valid = |cand;
    grant_idx   = 1'b0;
    if (cand == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_idx = 1'b0;
`else
      grant_idx = ~last_grant;
`endif
    end else begin
      grant_idx = cand[1];
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = grant_valid ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = grant_valid ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      owner      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state_reg <= state_next;
      if (grant_valid) begin
        addr_q     <= grant_idx ? addr1  : addr0;
        we_q       <= grant_idx ? wr1    : wr0;
        din_q      <= grant_idx ? wdata1 : wdata0;
        owner      <= grant_idx;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_grant <= grant_idx;
`endif
      end
    end
  end

  // Per-port read-data register and ack decode.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (state_reg == ACCESS && !we_q && owner == 1'(gi)) begin
          rdata_reg <= mem_dout;
        end
      end

      assign ack_vec[gi] = (state_reg == RESP) && (owner == 1'(gi));
    end
  endgenerate

  assign rdata0 = g_port[0].rdata_reg;
  assign rdata1 = g_port[1].rdata_reg;
  assign ack0   = ack_vec[0];
  assign ack1   = ack_vec[1];

  // mem_write is gated by reset so that a reset arriving during ACCESS
  // cancels the write before the memory's capturing edge.
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign mem_write = (state_reg == ACCESS) & we_q & ~reset;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, wr0, req1, wr1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_write, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wr0(wr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wr1(wr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Memory attached to the arbiter: combinational read, write on rising clk.
  logic [31:0] mem [512];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_din;

  // Reference contents: updated at each write ack.
  // Accesses are serialised, so the ack order is the memory order.
  logic [31:0] ref_mem [512];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mw_cycles = 0;
  logic [8:0] mw_addr = '0;
  int ack_port[$];
  int ack_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_write) begin
      mw_cycles++;
      mw_addr = mem_addr;
    end
    if (ack0 | ack1) begin
      check("ack_exclusive", {62'd0, ack0, ack1}, (ack0 ? 64'd2 : 64'd1));
      ack_port.push_back(ack1 ? 1 : 0);
      ack_cyc.push_back(cyc);
    end
  end

  // One transaction on port p.
  // Drives the fields, waits (bounded) for the ack, and checks or updates
  // the reference memory at ack time.
  // It releases req one edge after the ack and returns at posedge+1.
  task automatic issue(input int p, input logic [8:0] a, input logic w, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
    logic got;
    if (p == 0) begin addr0 = a; wr0 = w; wdata0 = d; req0 = 1'b1; end
    else        begin addr1 = a; wr1 = w; wdata1 = d; req1 = 1'b1; end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) check("ack_timeout", 64'd0, 64'd1);
    rd = (p == 0) ? rdata0 : rdata1;
    if (got) begin
      if (w) ref_mem[a] = d;
      else   check($sformatf("rdata%0d_%0h", p, a), rd, ref_mem[a]);
    end
    $display("txn port=%0d %s addr=%03h data=%08h lat=%0d", p, w ? "WR" : "RD", a, w ? d : rd, lat);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int lat;
    logic [31:0] rd;
    for (int k = 0; k < n; k++) begin
      issue(p, 9'h100 + 9'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, lat, rd);
      // At most one access of the other port can be ahead of this one.
      check("lat_bound", {63'd0, (lat >= 2 && lat <= 5)}, 64'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat2, n_before;
    logic [31:0] rd, rd2;
    reset = 1'b1;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[9'h010] = 32'hDEADBEEF; ref_mem[9'h010] = 32'hDEADBEEF;
    mem[9'h040] = 32'h00000055; ref_mem[9'h040] = 32'h00000055;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", {63'd0, ack0}, 0);
    check("rst_ack1", {63'd0, ack1}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_write", {63'd0, mem_write}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    reset = 1'b0;

    // Uncontended read, driven at negedge: ack two edges later.
    mw_cycles = 0;
    issue(0, 9'h010, 1'b0, 0, lat, rd);
    check("read_latency", lat, 2);
    check("read_deadbeef", rd, 32'hDEADBEEF);
    check("read_no_write", mw_cycles, 0);

    // Port 1 write, then port 0 read back.
    mw_cycles = 0;
    issue(1, 9'h1FF, 1'b1, 32'h12345678, lat, rd);
    check("write_pulse_cycles", mw_cycles, 1);
    check("write_addr", mw_addr, 9'h1FF);
    issue(0, 9'h1FF, 1'b0, 0, lat, rd);
    check("readback_1ff", rd, 32'h12345678);

    // A write leaves the owner's rdata untouched.
    issue(0, 9'h040, 1'b0, 0, lat, rd);
    check("read_55", rd, 32'h55);
    issue(0, 9'h030, 1'b1, 32'hCAFEF00D, lat, rd);
    check("rdata_held_after_write", rdata0, 32'h55);

    // A single port re-requesting back-to-back is served every 3 cycles.
    ack_cyc.delete(); ack_port.delete();
    for (int k = 0; k < 3; k++) issue(0, 9'($urandom_range(0, 511)), 1'b0, 0, lat, rd);
    check("b2b_count", ack_cyc.size(), 3);
    if (ack_cyc.size() == 3) begin
      check("b2b_gap0", ack_cyc[1] - ack_cyc[0], 3);
      check("b2b_gap1", ack_cyc[2] - ack_cyc[1], 3);
    end

    // Both ports contending from a fresh reset: order 0,1,0,1 every 2 cycles.
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    ack_cyc.delete(); ack_port.delete();
    fork
      begin
        issue(0, 9'h001, 1'b0, 0, lat, rd);
        issue(0, 9'h001, 1'b0, 0, lat, rd);
      end
      begin
        issue(1, 9'h002, 1'b0, 0, lat2, rd2);
        issue(1, 9'h002, 1'b0, 0, lat2, rd2);
      end
    join
    check("contend_count", ack_port.size(), 4);
    if (ack_port.size() == 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("contend_order%0d", k), ack_port[k], k % 2);
      for (int k = 1; k < 4; k++) check($sformatf("contend_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 2);
    end

    // Reset during ACCESS of a port 1 write: no write, no ack, outputs reset.
    @(negedge clk);
    addr1 = 9'h020; wr1 = 1'b1; wdata1 = 32'hAAAAAAAA; req1 = 1'b1;
    n_before = ack_port.size();
    @(negedge clk);
    check("abort_in_access", {63'd0, busy}, 1);
    reset = 1'b1;
    #1;
    check("abort_write_gated", {63'd0, mem_write}, 0);
    @(negedge clk);
    check("abort_ack1", {63'd0, ack1}, 0);
    check("abort_busy", {63'd0, busy}, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_din", mem_din, 0);
    check("abort_mem_write", {63'd0, mem_write}, 0);
    check("abort_rdata0", rdata0, 0);
    check("abort_rdata1", rdata1, 0);
    req1 = 1'b0; wr1 = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ack", ack_port.size(), n_before);
    check("abort_mem_020", mem[9'h020], ref_mem[9'h020]);

    // Randomised traffic on both ports against the reference memory.
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the 512 x 32 unified memory (combinational read, write on rising clk). Port 0 is instruction fetch, port 1 is the datapath load/store unit. The block serialises their accesses onto the single memory port and drives the memory's Address/Datain/Write pins. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- ADDR_W, 9, memory address width (512 words)
- DATA_W, 32, memory word width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held with addr0/wr0/wdata0 stable until ack0
- addr0  in  ADDR_W  port 0 word address
- wr0  in  1  port 0 write (1) / read (0)
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 completion pulse, 1 cycle
- rdata0  out  DATA_W  port 0 read data, valid while ack0=1, held until next port 0 read
- req1, addr1, wr1, wdata1, ack1, rdata1: same as port 0, for port 1
- mem_addr  out  ADDR_W  to memory Address
- mem_din  out  DATA_W  to memory Datain
- mem_write  out  1  to memory Write
- mem_dout  in  DATA_W  from memory Dataout (combinational)
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick a winner and latch its addr/wr/wdata into addr_q/we_q/din_q and its index into owner. Next state ACCESS. Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr=addr_q, mem_din=din_q, mem_write=we_q & ~reset.
  - On the closing edge: the memory captures a write, or rdata[owner] latches mem_dout for a read.
  - Next state RESP.
- RESP (1 cycle): ack[owner]=1. The other requester is arbitrated in this cycle; the owner's req is ignored here because it is stale.
  - Other requester's req=1: latch it, go directly to ACCESS.
  - Otherwise: go to IDLE.
- Arbitration (default, round-robin): on a tie, the port not in last_grant wins. last_grant updates whenever a winner is latched. Reset sets last_grant=1, so port 0 wins the first tie.
- On a write, rdata of the owner is unchanged.
- mem_addr and mem_din hold their last latched values outside ACCESS. mem_write is 0 outside ACCESS.
- Reset values: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, mem_addr=0, mem_din=0, mem_write=0, busy=0, last_grant=1.
- Reset mid-operation:
  - Reset high during ACCESS suppresses mem_write in that cycle, so no memory write occurs.
  - The in-flight access is dropped with no ack. The requester must re-request after reset.
- Address arithmetic: none. Addresses pass through unmodified; no wrap or bounds logic.

## Timing
- Uncontended access: req sampled in IDLE at edge N. ACCESS during cycle N+1. ack high during cycle N+2 with rdata valid. Latency is 2 cycles from the sampling edge.
- Sustained alternation of both ports (RESP->ACCESS): one access every 2 cycles.
- A single port re-requesting back-to-back: one access every 3 cycles (RESP->IDLE->ACCESS).
- Requester may deassert req, or change its request fields, at the edge ending its ack cycle. It must not change them between its request and ack.
- ack0 and ack1 are never high in the same cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Port 0 (fetch) always wins ties in IDLE. In RESP, port 1 still gets the handoff if port 0 was the owner. last_grant is unused.
  - Undefined: round-robin as above.

## Test plan
- Reset then single read: preload mem[0x010]=0xDEADBEEF; req0=1, addr0=0x010, wr0=0 -> ack0 two cycles after sampling edge, rdata0=0xDEADBEEF; mem_write stays 0 throughout.
- Write then read back: port 1 writes 0x12345678 to 0x1FF -> mem_write high exactly 1 cycle with mem_addr=0x1FF; subsequent port 0 read of 0x1FF returns 0x12345678.
- Simultaneous requests, round-robin: req0 and req1 both held, reading 0x001 and 0x002 -> grant order 0,1,0,1; acks alternate every 2 cycles; never both high.
- Same stimulus with MEM_ARB_FIXED_PRIO_EN defined and req0 re-asserted each ack -> order 0,1,0,1 via RESP handoff. With only req0 active, port 0 is served every 3 cycles.
- Reset during ACCESS of a port 1 write of 0xAAAAAAAA to 0x020 -> mem[0x020] unchanged, no ack1, all outputs at reset values next cycle.
- Write does not disturb rdata: port 0 reads 0x55 (rdata0=0x55) then writes to 0x030 -> rdata0 stays 0x55 after the write's ack0.
